// File: rtl/hir_arith_pkg.sv
// hir_arith_pkg: shared sizing and saturation helpers for the HIR arithmetic pipes.
package hir_arith_pkg;
  localparam int MAX_ACC = 160;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
  function automatic int wsum_latency(input int taps, input int mul_stages);
    return mul_stages + clog2(taps) + 1;
  endfunction
  function automatic int acc_width(input int width, input int taps);
    return 2 * width + clog2(taps);
  endfunction
  function automatic logic signed [63:0] sat_narrow(input logic signed [MAX_ACC-1:0] x, input int w);
    logic signed [MAX_ACC-1:0] hi, lo;
    hi = (MAX_ACC'(1) << (w - 1)) - 1;
    lo = ~hi;
    return 64'(x > hi ? hi : (x < lo ? lo : x));
  endfunction
endpackage

// File: rtl/hir_pipe_mul.sv
// hir_pipe_mul: signed WIDTHxWIDTH -> 2*WIDTH multiplier with STAGES enable-gated registers.
module hir_pipe_mul
  import hir_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [STAGES-1:0]           en,
  input  logic signed [WIDTH-1:0]     a,
  input  logic signed [WIDTH-1:0]     b,
  output logic signed [2*WIDTH-1:0]   p
);
  localparam int P = 2 * WIDTH;
  logic signed [P-1:0] prod_q [STAGES];
  logic signed [P-1:0] prod_d [STAGES];
  always_comb begin
    prod_d[0] = en[0] ? P'(a) * P'(b) : prod_q[0];
    for (int s = 1; s < STAGES; s++) prod_d[s] = en[s] ? prod_q[s-1] : prod_q[s];
  end
  always_ff @(posedge clk) begin
    if (rst) prod_q <= '{default: '0};
    else prod_q <= prod_d;
  end
  assign p = prod_q[STAGES-1];
endmodule

// File: rtl/hir_weighted_sum_pipe.sv
// hir_weighted_sum_pipe: pipelined N-tap weighted sum (sum v*wt) >>> SHIFT with valid token.
// Define HIR_WSUM_SATURATE_EN to clamp the narrowed result instead of wrapping.
module hir_weighted_sum_pipe
  import hir_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAPS = 4,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     t,
  input  logic [TAPS*WIDTH-1:0]    v,
  input  logic [TAPS*WIDTH-1:0]    wt,
  output logic [WIDTH-1:0]         result,
  output logic                     t_out
);
  localparam int P = 2 * WIDTH;
  localparam int LV = clog2(TAPS);
  localparam int ACC_W = acc_width(WIDTH, TAPS);
  localparam int L = wsum_latency(TAPS, MUL_STAGES);
  localparam int OUT_EN = MUL_STAGES + LV - 1;
  logic [L-1:0] vld_q, vld_d;
  logic [MUL_STAGES-1:0] mul_en;
  logic signed [P-1:0] prod [TAPS];
  logic signed [WIDTH-1:0] result_q, result_d;
  always_comb begin
    vld_d = {vld_q[L-2:0], t};
    mul_en = MUL_STAGES'({vld_q, t});
  end
  for (genvar i = 0; i < TAPS; i++) begin : tap
    hir_pipe_mul #(.WIDTH(WIDTH), .STAGES(MUL_STAGES)) u_mul (
      .clk(clk),
      .rst(rst),
      .en(mul_en),
      .a(v[i*WIDTH +: WIDTH]),
      .b(wt[i*WIDTH +: WIDTH]),
      .p(prod[i])
    );
  end
  // Every tree node is kept at ACC_W; sign extension makes this equal to growing one bit per level.
  for (genvar j = 0; j <= LV; j++) begin : lvl
    localparam int N = (TAPS + (1 << j) - 1) >> j;
    logic signed [ACC_W-1:0] node [N];
    if (j == 0) begin : leaf
      for (genvar i = 0; i < N; i++) begin : e
        assign node[i] = ACC_W'(prod[i]);
      end
    end else begin : sum
      localparam int NP = (TAPS + (1 << (j - 1)) - 1) >> (j - 1);
      logic signed [ACC_W-1:0] sum_q [N];
      logic signed [ACC_W-1:0] sum_d [N];
      for (genvar i = 0; i < N; i++) begin : e
        if (2 * i + 1 < NP) begin : pair
          assign sum_d[i] = vld_q[MUL_STAGES+j-2] ? lvl[j-1].node[2*i] + lvl[j-1].node[2*i+1] : sum_q[i];
        end else begin : odd
          assign sum_d[i] = vld_q[MUL_STAGES+j-2] ? lvl[j-1].node[2*i] : sum_q[i];
        end
      end
      always_ff @(posedge clk) begin
        if (rst) sum_q <= '{default: '0};
        else sum_q <= sum_d;
      end
      assign node = sum_q;
    end
  end
  always_comb begin
`ifdef HIR_WSUM_SATURATE_EN
    result_d = vld_q[OUT_EN] ? WIDTH'(sat_narrow(MAX_ACC'(lvl[LV].node[0] >>> SHIFT), WIDTH)) : result_q;
`else
    result_d = vld_q[OUT_EN] ? WIDTH'(lvl[LV].node[0] >>> SHIFT) : result_q;
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      result_q <= '0;
    end else begin
      vld_q <= vld_d;
      result_q <= result_d;
    end
  end
  assign result = result_q;
  assign t_out = vld_q[L-1];
endmodule

// File: tb/tb_hir_weighted_sum_pipe.sv
// tb_hir_weighted_sum_pipe: directed and randomized checks of four weighted-sum configurations.
module tb_hir_weighted_sum_pipe;
  logic clk = 0, rst = 1;
  int cyc = 0, n_cmp = 0, n_bad = 0;
  logic t_a, t_b, t_c, t_d, to_a, to_b, to_c, to_d;
  logic [127:0] v_a, wt_a;
  logic [95:0] v_b, wt_b;
  logic [31:0] v_c, wt_c;
  logic [31:0] v_d, wt_d;
  logic [31:0] res_a, res_b, res_d;
  logic [7:0] res_c;
  localparam int LAT [4] = '{5, 5, 5, 2};
  localparam int W [4] = '{32, 32, 8, 32};
  localparam int TP [4] = '{4, 3, 4, 1};
  localparam int SH [4] = '{0, 4, 0, 0};
  longint exp_q [4][$];
  int due_q [4][$];

  hir_weighted_sum_pipe #(.WIDTH(32), .TAPS(4), .MUL_STAGES(2), .SHIFT(0)) u_a (
    .clk(clk), .rst(rst), .t(t_a), .v(v_a), .wt(wt_a), .result(res_a), .t_out(to_a));
  hir_weighted_sum_pipe #(.WIDTH(32), .TAPS(3), .MUL_STAGES(2), .SHIFT(4)) u_b (
    .clk(clk), .rst(rst), .t(t_b), .v(v_b), .wt(wt_b), .result(res_b), .t_out(to_b));
  hir_weighted_sum_pipe #(.WIDTH(8), .TAPS(4), .MUL_STAGES(2), .SHIFT(0)) u_c (
    .clk(clk), .rst(rst), .t(t_c), .v(v_c), .wt(wt_c), .result(res_c), .t_out(to_c));
  hir_weighted_sum_pipe #(.WIDTH(32), .TAPS(1), .MUL_STAGES(1), .SHIFT(0)) u_d (
    .clk(clk), .rst(rst), .t(t_d), .v(v_d), .wt(wt_d), .result(res_d), .t_out(to_d));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic longint model(input int d, input longint va[4], input longint wa[4]);
    logic signed [127:0] acc;
`ifdef HIR_WSUM_SATURATE_EN
    logic signed [127:0] hi, lo;
`endif
    acc = 0;
    for (int i = 0; i < TP[d]; i++) acc += 128'(va[i]) * 128'(wa[i]);
    acc = acc >>> SH[d];
`ifdef HIR_WSUM_SATURATE_EN
    hi = (128'sd1 <<< (W[d] - 1)) - 1;
    lo = -hi - 1;
    if (acc > hi) acc = hi;
    else if (acc < lo) acc = lo;
`else
    acc = (acc <<< (128 - W[d])) >>> (128 - W[d]);
`endif
    return longint'(acc);
  endfunction

  function automatic longint rand_val(input int w);
    logic signed [63:0] x;
    x = {$urandom, $urandom};
    return longint'((x <<< (64 - w)) >>> (64 - w));
  endfunction

  function automatic longint res_of(input int d);
    case (d)
      0: return longint'($signed(res_a));
      1: return longint'($signed(res_b));
      2: return longint'($signed(res_c));
      default: return longint'($signed(res_d));
    endcase
  endfunction

  function automatic logic tout_of(input int d);
    case (d)
      0: return to_a;
      1: return to_b;
      2: return to_c;
      default: return to_d;
    endcase
  endfunction

  task automatic drive(input int d, input logic tt, input longint va[4], input longint wa[4]);
    case (d)
      0: begin
        t_a = tt;
        for (int i = 0; i < 4; i++) begin v_a[i*32 +: 32] = va[i][31:0]; wt_a[i*32 +: 32] = wa[i][31:0]; end
        if (!tt) begin v_a = 'x; wt_a = 'x; end
      end
      1: begin
        t_b = tt;
        for (int i = 0; i < 3; i++) begin v_b[i*32 +: 32] = va[i][31:0]; wt_b[i*32 +: 32] = wa[i][31:0]; end
        if (!tt) begin v_b = 'x; wt_b = 'x; end
      end
      2: begin
        t_c = tt;
        for (int i = 0; i < 4; i++) begin v_c[i*8 +: 8] = va[i][7:0]; wt_c[i*8 +: 8] = wa[i][7:0]; end
        if (!tt) begin v_c = 'x; wt_c = 'x; end
      end
      default: begin
        t_d = tt;
        v_d = va[0][31:0];
        wt_d = wa[0][31:0];
        if (!tt) begin v_d = 'x; wt_d = 'x; end
      end
    endcase
  endtask

  task automatic idle(input int d);
    longint z [4] = '{default: 0};
    drive(d, 1'b0, z, z);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1;
    for (int d = 0; d < 4; d++) idle(d);
    repeat (3) tick();
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (tout_of(d) !== 1'b0) begin n_bad++; $display("FAIL reset_tout dut=%0d got=%b want=0", d, tout_of(d)); end
      n_cmp++;
      if (res_of(d) !== 0) begin n_bad++; $display("FAIL reset_result dut=%0d got=%0d want=0", d, res_of(d)); end
    end
    tick();
    rst = 0;
  endtask

  task automatic test_basic();
    longint va [4], wa [4];
    int due;
    va = '{1, 2, 3, 4};
    wa = '{5, 6, 7, 8};
    drive(0, 1'b1, va, wa);
    due = cyc + 5;
    tick();
    idle(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tout_of(0) !== (cyc == due)) begin n_bad++; $display("FAIL basic_tout cyc=%0d got=%b want=%b", cyc, tout_of(0), cyc == due); end
      if (cyc == due) begin
        n_cmp++;
        if (res_of(0) !== 70) begin n_bad++; $display("FAIL basic_result got=%0d want=70", res_of(0)); end
      end
      tick();
    end
  endtask

  task automatic test_stream();
    longint va [4], wa [4];
    longint want;
    int due;
    va = '{1, 1, 1, 1};
    due = cyc + 5;
    for (int k = 1; k <= 3; k++) begin
      wa = '{k, k, k, k};
      drive(0, 1'b1, va, wa);
      tick();
    end
    idle(0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      want = cyc < due ? 70 : (cyc > due + 2 ? 12 : 4 * (cyc - due + 1));
      n_cmp++;
      if (tout_of(0) !== (cyc >= due && cyc <= due + 2)) begin n_bad++; $display("FAIL stream_tout cyc=%0d got=%b", cyc, tout_of(0)); end
      n_cmp++;
      if (res_of(0) !== want) begin n_bad++; $display("FAIL stream_result cyc=%0d got=%0d want=%0d", cyc, res_of(0), want); end
      tick();
    end
  endtask

  task automatic test_signed_shift();
    longint va [4], wa [4];
    longint want;
    int due;
    va = '{16, 32, -16, 0};
    wa = '{1, 2, 1, 0};
    drive(1, 1'b1, va, wa);
    due = cyc + 5;
    tick();
    va = '{-1, 0, 0, 0};
    wa = '{1, 0, 0, 0};
    drive(1, 1'b1, va, wa);
    tick();
    idle(1);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      want = cyc < due ? 0 : (cyc == due ? 4 : -1);
      n_cmp++;
      if (tout_of(1) !== (cyc == due || cyc == due + 1)) begin n_bad++; $display("FAIL shift_tout cyc=%0d got=%b", cyc, tout_of(1)); end
      n_cmp++;
      if (res_of(1) !== want) begin n_bad++; $display("FAIL shift_result cyc=%0d got=%0d want=%0d", cyc, res_of(1), want); end
      tick();
    end
  endtask

  task automatic test_overflow();
    longint va [4], wa [4];
    longint want, pos, neg;
    int due;
`ifdef HIR_WSUM_SATURATE_EN
    pos = 127;
    neg = -128;
`else
    pos = 44;
    neg = -44;
`endif
    va = '{100, 100, 0, 0};
    wa = '{2, 1, 0, 0};
    drive(2, 1'b1, va, wa);
    due = cyc + 5;
    tick();
    va = '{-100, -100, 0, 0};
    drive(2, 1'b1, va, wa);
    tick();
    idle(2);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      want = cyc < due ? 0 : (cyc == due ? pos : neg);
      n_cmp++;
      if (tout_of(2) !== (cyc == due || cyc == due + 1)) begin n_bad++; $display("FAIL ovf_tout cyc=%0d got=%b", cyc, tout_of(2)); end
      n_cmp++;
      if (res_of(2) !== want) begin n_bad++; $display("FAIL ovf_result cyc=%0d got=%0d want=%0d", cyc, res_of(2), want); end
      tick();
    end
  endtask

  task automatic test_reset_midflight();
    longint va [4], wa [4];
    int due;
    va = '{7, 7, 7, 7};
    wa = '{3, 3, 3, 3};
    drive(0, 1'b1, va, wa);
    tick();
    drive(0, 1'b1, va, wa);
    tick();
    idle(0);
    rst = 1;
    tick();
    rst = 0;
    tick();
    va = '{2, 3, 4, 5};
    wa = '{1, 1, 1, 1};
    drive(0, 1'b1, va, wa);
    due = cyc + 5;
    tick();
    idle(0);
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tout_of(0) !== (cyc == due)) begin n_bad++; $display("FAIL midrst_tout cyc=%0d got=%b want=%b", cyc, tout_of(0), cyc == due); end
      n_cmp++;
      if (res_of(0) !== (cyc >= due ? 64'sd14 : 64'sd0)) begin n_bad++; $display("FAIL midrst_result cyc=%0d got=%0d", cyc, res_of(0)); end
      tick();
    end
  endtask

  task automatic test_edge();
    longint va [4], wa [4];
    int due;
    va = '{-7, 0, 0, 0};
    wa = '{3, 0, 0, 0};
    drive(3, 1'b1, va, wa);
    due = cyc + 2;
    tick();
    idle(3);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tout_of(3) !== (cyc == due)) begin n_bad++; $display("FAIL edge_tout cyc=%0d got=%b want=%b", cyc, tout_of(3), cyc == due); end
      if (cyc == due) begin
        n_cmp++;
        if (res_of(3) !== -21) begin n_bad++; $display("FAIL edge_result got=%0d want=-21", res_of(3)); end
      end
      tick();
    end
    rst = 1;
    drive(3, 1'b1, va, wa);
    tick();
    rst = 0;
    idle(3);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++;
      if (tout_of(3) !== 1'b0) begin n_bad++; $display("FAIL edge_rst_tout cyc=%0d got=%b want=0", cyc, tout_of(3)); end
      n_cmp++;
      if (res_of(3) !== 0) begin n_bad++; $display("FAIL edge_rst_result cyc=%0d got=%0d want=0", cyc, res_of(3)); end
      tick();
    end
  endtask

  task automatic test_random();
    longint va [4], wa [4];
    longint last [4] = '{default: 0};
    logic tt, want;
    rst = 1;
    for (int d = 0; d < 4; d++) idle(d);
    tick();
    rst = 0;
    for (int c = 0; c < 300; c++) begin
      for (int d = 0; d < 4; d++) begin
        tt = c < 290 && $urandom_range(0, 3) != 0;
        for (int i = 0; i < 4; i++) begin va[i] = rand_val(W[d]); wa[i] = rand_val(W[d]); end
        drive(d, tt, va, wa);
        if (tt) begin
          exp_q[d].push_back(model(d, va, wa));
          due_q[d].push_back(cyc + LAT[d]);
        end
      end
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        want = due_q[d].size() != 0 && due_q[d][0] == cyc;
        n_cmp++;
        if (tout_of(d) !== want) begin n_bad++; $display("FAIL rand_tout dut=%0d cyc=%0d got=%b want=%b", d, cyc, tout_of(d), want); end
        if (want) begin
          last[d] = exp_q[d].pop_front();
          void'(due_q[d].pop_front());
        end
        n_cmp++;
        if (res_of(d) !== last[d]) begin n_bad++; $display("FAIL rand_result dut=%0d cyc=%0d got=%0d want=%0d", d, cyc, res_of(d), last[d]); end
      end
      tick();
    end
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (due_q[d].size() != 0) begin n_bad++; $display("FAIL rand_drain dut=%0d got=%0d left want=0", d, due_q[d].size()); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stream();
    test_signed_shift();
    test_overflow();
    test_reset_midflight();
    test_edge();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
